// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential signed binary-to-BCD converter (double-dabble).
// Accepts a two's-complement value, converts its magnitude to DIGITS BCD
// digits over WIDTH shift cycles, optionally blanks leading zeros, and holds
// the result with a valid/ready handshake. The sign is reported separately.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_value,
   input  logic                  blank_lz,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_digits,
   output logic                  out_neg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      BLANK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_r;
   logic [WIDTH-1:0] mag_r;
   logic [BW-1:0]    bcd_r;
   logic [CW-1:0]    cnt_r;
   logic             blank_r;
   logic             neg_r;

   logic [BW-1:0]    bcd_adj_s;
   logic [BW-1:0]    blanked_s;
   logic [WIDTH-1:0] mag_in_s;
   logic             lz_s;

   // Double-dabble correction: a digit of 5..9 gets 3 added so the
   // following left shift carries correctly into the next decade.
   function automatic logic [3:0] add3(input logic [3:0] d);
      logic [3:0] r;
      if (d >= 4'd5) begin
         r = d + 4'd3;
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Magnitude of the incoming value; the most negative value maps to
   // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
   always_comb begin
      mag_in_s = in_value;
      if (in_value[WIDTH-1]) begin
         mag_in_s = (~in_value) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag_in_s = in_value;
      end
   end

   // Per-digit add-3 applied to the whole BCD register before each shift.
   always_comb begin
      bcd_adj_s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         bcd_adj_s[4*i +: 4] = add3(bcd_r[4*i +: 4]);
      end
   end

   // Leading-zero blanking: walk from the top digit down, turning zeros into
   // 4'hF until the first nonzero digit; digit 0 always stays visible.
   always_comb begin
      blanked_s = bcd_r;
      lz_s      = blank_r;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lz_s && (bcd_r[4*i +: 4] == 4'd0)) begin
            blanked_s[4*i +: 4] = 4'hF;
         end else begin
            lz_s = 1'b0;
         end
      end
   end

   // Control FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_digits <= '0;
         out_neg    <= 1'b0;
         mag_r      <= '0;
         bcd_r      <= '0;
         cnt_r      <= '0;
         blank_r    <= 1'b0;
         neg_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  neg_r    <= in_value[WIDTH-1];
                  mag_r    <= mag_in_s;
                  blank_r  <= blank_lz;
                  bcd_r    <= '0;
                  cnt_r    <= CW'(WIDTH);
                  in_ready <= 1'b0;
                  state_r  <= SHIFT;
               end else begin
                  state_r  <= IDLE;
               end
            end
            SHIFT: begin
               bcd_r <= {bcd_adj_s[BW-2:0], mag_r[WIDTH-1]};
               mag_r <= {mag_r[WIDTH-2:0], 1'b0};
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  state_r <= BLANK;
               end else begin
                  state_r <= SHIFT;
               end
            end
            BLANK: begin
               out_digits <= blanked_s;
               out_neg    <= neg_r;
               out_valid  <= 1'b1;
               state_r    <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  state_r   <= DONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: the driver pushes hand-computed
// expected results; a monitor checks latency and data at each output handshake.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic        blank_lz;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_digits;
   logic        out_neg;

   typedef struct {
      logic [19:0] digits;
      logic        neg;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests;
   int   fails;
   int   cyc;
   logic prev_valid;

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .blank_lz   (blank_lz),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_digits (out_digits),
      .out_neg    (out_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter used for latency measurement.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: latency on rising out_valid, data on each output handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               check("latency", 32'(cyc - sb[0].acc), 32'd17);
            end
         end
         if (out_valid && out_ready && (sb.size() != 0)) begin
            mon_e = sb.pop_front();
            check("out_digits", 32'(out_digits), 32'(mon_e.digits));
            check("out_neg", 32'(out_neg), 32'(mon_e.neg));
         end
      end
      prev_valid = out_valid;
   end

   task automatic convert(input logic [15:0] v, input logic bl,
                          input logic [19:0] ed, input logic en);
      exp_t e;
      int   n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
      end else begin
         @(negedge clk);
         in_valid = 1'b1;
         in_value = v;
         blank_lz = bl;
         @(posedge clk);
         #1;
         e.digits = ed;
         e.neg    = en;
         e.acc    = cyc;
         sb.push_back(e);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      prev_valid = 1'b0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_value   = 16'd0;
      blank_lz   = 1'b0;
      out_ready  = 1'b1;

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_digits", 32'(out_digits), 32'h00000);
      check("rst_out_neg", 32'(out_neg), 32'd0);

      // Basic conversion, valid held one cycle with out_ready high
      convert(16'd12345, 1'b0, 20'h12345, 1'b0);
      wait_valid();
      @(negedge clk);
      check("held_one_cycle", 32'(out_valid), 32'd0);
      check("ready_after_done", 32'(in_ready), 32'd1);
      wait_done();

      // Negative and blanking vectors
      convert(16'h8000, 1'b1, 20'h32768, 1'b1); wait_done();
      convert(16'hFFFF, 1'b1, 20'hFFFF1, 1'b1); wait_done();
      convert(16'd42,   1'b1, 20'hFFF42, 1'b0); wait_done();
      convert(16'd42,   1'b0, 20'h00042, 1'b0); wait_done();
      convert(16'd0,    1'b1, 20'hFFFF0, 1'b0); wait_done();
      convert(16'd10000,1'b1, 20'h10000, 1'b0); wait_done();
      convert(16'hFF9C, 1'b1, 20'hFF100, 1'b1); wait_done();
      convert(16'd32767,1'b0, 20'h32767, 1'b0); wait_done();

      // Backpressure with in_valid pulses while DONE
      out_ready = 1'b0;
      convert(16'd42, 1'b1, 20'hFFF42, 1'b0);
      wait_valid();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = (k % 2 == 0);
         in_value = 16'd7;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_digits", 32'(out_digits), 32'hFFF42);
         check("bp_neg", 32'(out_neg), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      wait_done();
      repeat (25) @(negedge clk);
      check("bp_no_capture", 32'(in_ready), 32'd1);

      // Reset during the 8th shift cycle of 999, then convert 9
      @(negedge clk);
      in_valid = 1'b1;
      in_value = 16'd999;
      blank_lz = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_digits", 32'(out_digits), 32'h00000);
      repeat (25) @(negedge clk);
      check("midrst_idle", 32'(in_ready), 32'd1);
      convert(16'd9, 1'b0, 20'h00009, 1'b0);
      wait_done();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential signed binary-to-BCD converter for the calculator display path. It takes a two's-complement result from the arithmetic unit and produces one 4-bit BCD code per display digit, with optional leading-zero blanking. Each digit output drives one seven-segment digit decoder directly. The sign is reported separately so the display can light a minus indicator.

## Interface

**Parameters**
- WIDTH, 16, width of the signed input value.
- DIGITS, 5, number of BCD output digits. The integrator must guarantee 10^DIGITS > 2^(WIDTH-1); magnitudes that do not fit are unsupported.

**Ports**
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_value and blank_lz are valid.
- in_ready  out  1  block can accept a new value; high only in IDLE.
- in_value  in  WIDTH  two's-complement value to convert.
- blank_lz  in  1  leading-zero blank request; sampled with in_value.
- out_valid  out  1  out_digits and out_neg hold a finished result.
- out_ready  in  1  consumer accepts the result.
- out_digits  out  4*DIGITS  digit i is at [4i+3:4i]; digit 0 is the least significant. Codes are 0–9, or 4'hF for blank.
- out_neg  out  1  the converted value was negative.

## Operation

- States: IDLE, SHIFT, BLANK, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - Input is accepted on an edge where in_valid=1.
  - On acceptance:
    - neg ← in_value[WIDTH-1].
    - mag ← neg ? −in_value : in_value, as WIDTH-bit unsigned. −2^(WIDTH-1) gives magnitude 2^(WIDTH-1) correctly.
    - blank flag ← blank_lz.
    - BCD register ← 0.
    - Bit counter ← WIDTH.
    - Next state is SHIFT.
- **SHIFT** (double-dabble), once per cycle:
  - Every BCD digit ≥5 has 3 added to it.
  - Then {bcd, mag} shifts left by 1 bit.
  - The counter decrements.
  - After the WIDTH-th shift, next state is BLANK.
- **BLANK**, one cycle:
  - If the blank flag is set, digits from DIGITS-1 downward that equal 0 are replaced by 4'hF.
  - Replacement stops at the first nonzero digit.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Next state is DONE.
- **DONE**
  - out_valid=1.
  - out_digits and out_neg are held stable.
  - When out_ready=1, next state is IDLE.
- in_valid is ignored outside IDLE.
- out_digits and out_neg may change only during SHIFT/BLANK. They are defined only while out_valid=1.
- out_neg is never set for a zero result.
- **Reset**
  - After any edge with rst=1: state IDLE, in_ready=1, out_valid=0, out_digits=0, out_neg=0.
  - Reset takes priority over every other event.
  - Reset mid-conversion discards the operation; no out_valid is produced for it.

## Timing

- Acceptance edge E0 → SHIFT on edges E1..E(WIDTH) → BLANK on edge E(WIDTH+1) → out_valid high from the cycle after E(WIDTH+1).
- Latency is WIDTH+1 clock edges after acceptance; 17 for WIDTH=16.
- The out handshake edge returns the block to IDLE. The next acceptance is possible on the following edge.
- Minimum period is WIDTH+3 cycles per conversion: 19 for WIDTH=16, with out_ready held high.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Add-3 correction and shift happen in the same cycle. Per-digit add-3 logic is 4 bits wide; the carry from the add-3 is not needed.

## Test plan

- **Reset:** hold rst 2 cycles, release.
  - Required: in_ready=1, out_valid=0, out_digits=20'h00000, out_neg=0.
- **Basic conversion:** in_value=12345, blank_lz=0, out_ready=1.
  - Required: out_valid rises exactly 17 edges after acceptance, out_digits=20'h12345, out_neg=0, held for 1 cycle, then in_ready=1.
- **Negative extreme:** in_value=−32768 (16'h8000), blank_lz=1.
  - Required: out_digits=20'h32768, out_neg=1. Also in_value=−1 → 20'hFFFF1, out_neg=1.
- **Blanking:** blank_lz=1.
  - in_value=42 → 20'hFFF42.
  - in_value=0 → 20'hFFFF0, out_neg=0.
  - in_value=10000 → 20'h10000, with no interior zeros blanked.
- **Backpressure:** out_ready=0 for 10 cycles after out_valid, with in_valid pulsed meanwhile.
  - Required: outputs stable, in_ready=0, the pulsed input is not captured.
  - Raise out_ready → IDLE next edge.
- **Reset mid-conversion:** rst on the 8th SHIFT cycle of value 999, then convert 9.
  - Required: no out_valid for 999, in_ready=1 after reset, result 20'h00009 (blank_lz=0).
